// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE/LAP command FSM with an mm:ss.t
// counter, a lap snapshot and a sticky wrap flag.
module stopwatch_ctrl #(
  parameter int PRESCALE = 10,
  parameter int PW = $clog2(PRESCALE + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap_clr,
  output logic [3:0] tenths,
  output logic [5:0] secs,
  output logic [5:0] mins,
  output logic       running,
  output logic       lap_frozen,
  output logic       ovf
);

  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    LAP
  } state_t;

  state_t state, state_n;

  logic [PW-1:0] pre;
  logic [3:0]    t_q, t_n, t_snap, t_d;
  logic [5:0]    s_q, s_n, s_snap, s_d;
  logic [5:0]    m_q, m_n, m_snap, m_d;

  logic counting, tick;
  logic wrap_t, wrap_s, wrap_m;
  logic ovf_set, to_idle, take_snap;

  assign counting = (state == RUN) || (state == LAP);
  assign tick     = counting && (pre == PMAX);
  assign wrap_t   = (t_q == 4'd9);
  assign wrap_s   = (s_q == 6'd59);
  assign wrap_m   = (m_q == 6'd59);
  assign ovf_set  = tick && wrap_t && wrap_s && wrap_m;

  always_comb begin
    t_n = t_q;
    s_n = s_q;
    m_n = m_q;
    if (tick) begin
      if (!wrap_t) begin
        t_n = t_q + 4'd1;
      end else begin
        t_n = 4'd0;
        if (!wrap_s) begin
          s_n = s_q + 6'd1;
        end else begin
          s_n = 6'd0;
          m_n = wrap_m ? 6'd0 : m_q + 6'd1;
        end
      end
    end
  end

  // start_stop wins over lap_clr when both arrive together
  always_comb begin
    state_n   = state;
    to_idle   = 1'b0;
    take_snap = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_stop) state_n = RUN;
      end
      RUN: begin
        if (start_stop) begin
          state_n = PAUSE;
        end else if (lap_clr) begin
          state_n   = LAP;
          take_snap = 1'b1;
        end
      end
      PAUSE: begin
        if (start_stop) begin
          state_n = RUN;
        end else if (lap_clr) begin
          state_n = IDLE;
          to_idle = 1'b1;
        end
      end
      LAP: begin
        if (start_stop) state_n = PAUSE;
        else if (lap_clr) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase
  end

  // Display registers track whatever the next state will show
  always_comb begin
    t_d = t_n;
    s_d = s_n;
    m_d = m_n;
    if (state_n == LAP) begin
      if (take_snap) begin
        t_d = t_q;
        s_d = s_q;
        m_d = m_q;
      end else begin
        t_d = t_snap;
        s_d = s_snap;
        m_d = m_snap;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      pre        <= '0;
      t_q        <= '0;
      s_q        <= '0;
      m_q        <= '0;
      t_snap     <= '0;
      s_snap     <= '0;
      m_snap     <= '0;
      ovf        <= 1'b0;
      tenths     <= '0;
      secs       <= '0;
      mins       <= '0;
      running    <= 1'b0;
      lap_frozen <= 1'b0;
    end else if (to_idle) begin
      state      <= IDLE;
      pre        <= '0;
      t_q        <= '0;
      s_q        <= '0;
      m_q        <= '0;
      t_snap     <= '0;
      s_snap     <= '0;
      m_snap     <= '0;
      ovf        <= 1'b0;
      tenths     <= '0;
      secs       <= '0;
      mins       <= '0;
      running    <= 1'b0;
      lap_frozen <= 1'b0;
    end else begin
      state <= state_n;
      if (counting) begin
        pre <= (pre == PMAX) ? '0 : pre + 1'b1;
      end
      t_q <= t_n;
      s_q <= s_n;
      m_q <= m_n;
      if (take_snap) begin
        t_snap <= t_q;
        s_snap <= s_q;
        m_snap <= m_q;
      end
      if (ovf_set) ovf <= 1'b1;
      tenths     <= t_d;
      secs       <= s_d;
      mins       <= m_d;
      running    <= (state_n == RUN) || (state_n == LAP);
      lap_frozen <= (state_n == LAP);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl at PRESCALE=2 (one tick per
// two clocks); expectations queued by stimulus, compared on negedge.
module tb_stopwatch_ctrl;

  localparam int P = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_stop = 1'b0;
  logic       lap_clr = 1'b0;
  logic [3:0] tenths;
  logic [5:0] secs;
  logic [5:0] mins;
  logic       running;
  logic       lap_frozen;
  logic       ovf;

  stopwatch_ctrl #(.PRESCALE(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .lap_clr    (lap_clr),
    .tenths     (tenths),
    .secs       (secs),
    .mins       (mins),
    .running    (running),
    .lap_frozen (lap_frozen),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] m;
    logic [5:0] s;
    logic [3:0] t;
    logic       run;
    logic       lap;
    logic       ovf;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic expect_st(input string nm, input int m, input int s,
                           input int t, input logic r, input logic l,
                           input logic o);
    obs_t e;
    e.m   = 6'(m);
    e.s   = 6'(s);
    e.t   = 4'(t);
    e.run = r;
    e.lap = l;
    e.ovf = o;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin : monitor
    obs_t  e;
    obs_t  a;
    string nm;
    if (exp_q.size() > 0) begin
      e     = exp_q.pop_front();
      nm    = name_q.pop_front();
      a.m   = mins;
      a.s   = secs;
      a.t   = tenths;
      a.run = running;
      a.lap = lap_frozen;
      a.ovf = ovf;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: got %0d:%0d.%0d run=%b lap=%b ovf=%b, want %0d:%0d.%0d run=%b lap=%b ovf=%b",
                 nm, a.m, a.s, a.t, a.run, a.lap, a.ovf,
                 e.m, e.s, e.t, e.run, e.lap, e.ovf);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    cyc(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_lc();
    lap_clr = 1'b1;
    cyc(1);
    lap_clr = 1'b0;
  endtask

  task automatic pulse_both();
    start_stop = 1'b1;
    lap_clr    = 1'b1;
    cyc(1);
    start_stop = 1'b0;
    lap_clr    = 1'b0;
  endtask

  initial begin
    int k;
    cyc(2);
    expect_st("reset", 0, 0, 0, 0, 0, 0);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    expect_st("idle", 0, 0, 0, 0, 0, 0);
    pulse_lc();
    expect_st("idle_lapclr", 0, 0, 0, 0, 0, 0);

    pulse_ss();
    cyc(1);
    expect_st("start_lat", 0, 0, 0, 1, 0, 0);
    cyc(1);
    expect_st("first_tick", 0, 0, 1, 1, 0, 0);
    cyc(38);
    expect_st("run20", 0, 2, 0, 1, 0, 0);
    pulse_ss();
    expect_st("pause", 0, 2, 0, 0, 0, 0);
    pulse_lc();
    expect_st("clear", 0, 0, 0, 0, 0, 0);

    pulse_ss();
    cyc(14);
    expect_st("run7", 0, 0, 7, 1, 0, 0);
    pulse_ss();
    expect_st("paused7", 0, 0, 7, 0, 0, 0);
    cyc(10);
    expect_st("pause_hold", 0, 0, 7, 0, 0, 0);
    pulse_ss();
    cyc(5);
    expect_st("resume", 0, 1, 0, 1, 0, 0);
    pulse_ss();
    pulse_lc();
    expect_st("clear2", 0, 0, 0, 0, 0, 0);

    pulse_ss();
    cyc(68);
    expect_st("run34", 0, 3, 4, 1, 0, 0);
    pulse_lc();
    expect_st("lap_enter", 0, 3, 4, 1, 1, 0);
    cyc(20);
    expect_st("lap_hold", 0, 3, 4, 1, 1, 0);
    pulse_lc();
    expect_st("lap_release", 0, 4, 5, 1, 0, 0);
    pulse_ss();
    pulse_lc();

    pulse_ss();
    cyc(1200);
    expect_st("carry_min", 1, 0, 0, 1, 0, 0);
    cyc(70796);
    expect_st("at_59598", 59, 59, 8, 1, 0, 0);
    cyc(2);
    expect_st("at_59599", 59, 59, 9, 1, 0, 0);
    cyc(2);
    expect_st("wrap", 0, 0, 0, 1, 0, 1);
    cyc(2);
    expect_st("post_wrap", 0, 0, 1, 1, 0, 1);
    pulse_ss();
    expect_st("ovf_sticky", 0, 0, 1, 0, 0, 1);
    pulse_lc();
    expect_st("ovf_clear", 0, 0, 0, 0, 0, 0);

    pulse_ss();
    cyc(6);
    expect_st("run3", 0, 0, 3, 1, 0, 0);
    pulse_both();
    expect_st("both_pause", 0, 0, 3, 0, 0, 0);
    pulse_ss();
    expect_st("resume3", 0, 0, 3, 1, 0, 0);
    pulse_ss();
    expect_st("cmd_on_tick", 0, 0, 4, 0, 0, 0);
    pulse_lc();
    expect_st("clear3", 0, 0, 0, 0, 0, 0);

    pulse_ss();
    cyc(106);
    expect_st("run53", 0, 5, 3, 1, 0, 0);
    cyc(1);
    rst = 1'b0;
    expect_st("async_rst", 0, 0, 0, 0, 0, 0);
    cyc(2);
    rst = 1'b1;
    expect_st("post_rst", 0, 0, 0, 0, 0, 0);
    pulse_ss();
    cyc(2);
    expect_st("restart", 0, 0, 1, 1, 0, 0);

    k = 0;
    while (exp_q.size() > 0 && k < 10) begin
      cyc(1);
      k++;
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
